ex_div_stage: RTL and testbench

- Execute stage of the 5-stage MIPS pipeline; consumes the decode stage's operation and operands.
- Logic ops (and, or, xor, nor, plus ori/andi/xori/lui via the same op codes) produce a combinational result; wd_o/wreg_o/wdata_o also feed decode-stage forwarding.
- DIV/DIVU use an iterative 32-cycle restoring divider that writes HI/LO and stalls the pipeline via stallreq_o.

---
 rtl/ex_div_stage.sv | 181 ++++++++++++++++++
 tb/tb_ex_div_stage.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_div_stage.sv
// MIPS execute stage: combinational logic ops plus an iterative restoring divider
// (DIV/DIVU) that writes HI/LO and stalls the pipeline while it runs.
module ex_div_stage #(
    parameter int DATA_W     = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic              annul_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              whilo_o,
    output logic              stallreq_o
);

    localparam logic [7:0] EXE_NOP_OP    = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP    = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP     = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP    = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP    = 8'b0010_0111;
    localparam logic [7:0] EXE_DIV_OP    = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP   = 8'b0001_1011;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;

    localparam int CNT_W = $clog2(DIV_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_DONE
    } state_t;

    state_t              r_state;
    state_t              w_nextState;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W:0]     r_rem;
    logic [DATA_W-1:0]   r_quo;

    logic                w_isDiv;
    logic                w_isSigned;
    logic                w_divisorZero;
    logic [DATA_W-1:0]   w_dividendAbs;
    logic [DATA_W-1:0]   w_divisorAbs;
    logic [DATA_W+1:0]   w_shift;
    logic [DATA_W+1:0]   w_trial;
    logic                w_trialOk;
    logic                w_quoNeg;
    logic                w_remNeg;
    logic [DATA_W-1:0]   w_quoFinal;
    logic [DATA_W-1:0]   w_remFinal;
    logic                w_stall;
    logic                w_whilo;
    logic [DATA_W-1:0]   w_hi;
    logic [DATA_W-1:0]   w_lo;
    logic [DATA_W-1:0]   w_logicRes;
    logic                w_logicValid;

    assign w_isDiv       = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);
    assign w_isSigned    = (aluop_i == EXE_DIV_OP);
    assign w_divisorZero = (reg2_i == '0);
    assign w_dividendAbs = (w_isSigned && reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
    assign w_divisorAbs  = (w_isSigned && reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;

    // One restoring step: the top bit of the trial difference is its sign.
    assign w_shift   = {r_rem, r_quo[DATA_W-1]};
    assign w_trial   = w_shift - {2'b00, w_divisorAbs};
    assign w_trialOk = ~w_trial[DATA_W+1];

    assign w_quoNeg   = w_isSigned && (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
    assign w_remNeg   = w_isSigned && reg1_i[DATA_W-1];
    assign w_quoFinal = w_quoNeg ? -r_quo : r_quo;
    assign w_remFinal = w_remNeg ? -r_rem[DATA_W-1:0] : r_rem[DATA_W-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_quo   <= '0;
        end else begin
            r_state <= w_nextState;
            case (r_state)
                ST_IDLE: begin
                    if (w_isDiv && !annul_i && !w_divisorZero) begin
                        r_quo <= w_dividendAbs;
                        r_rem <= '0;
                        r_cnt <= '0;
                    end
                end
                ST_BUSY: begin
                    if (!annul_i) begin
                        r_rem <= w_trialOk ? w_trial[DATA_W:0] : w_shift[DATA_W:0];
                        r_quo <= {r_quo[DATA_W-2:0], w_trialOk};
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Flush overrides every state, including suppressing the DONE write.
    always_comb begin
        w_nextState = r_state;
        w_stall     = 1'b0;
        w_whilo     = 1'b0;
        w_hi        = '0;
        w_lo        = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_isDiv) begin
                    w_stall     = 1'b1;
                    w_nextState = w_divisorZero ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_stall = 1'b1;
                if (r_cnt == CNT_W'(DIV_CYCLES - 1)) begin
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                w_whilo     = 1'b1;
                w_nextState = ST_IDLE;
                if (!w_divisorZero) begin
                    w_hi = w_remFinal;
                    w_lo = w_quoFinal;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
        if (annul_i) begin
            w_nextState = ST_IDLE;
            w_stall     = 1'b0;
            w_whilo     = 1'b0;
            w_hi        = '0;
            w_lo        = '0;
        end
    end

    always_comb begin
        w_logicRes   = '0;
        w_logicValid = 1'b0;
        if (alusel_i == EXE_RES_LOGIC) begin
            case (aluop_i)
                EXE_AND_OP: begin w_logicRes = reg1_i & reg2_i;    w_logicValid = 1'b1; end
                EXE_OR_OP:  begin w_logicRes = reg1_i | reg2_i;    w_logicValid = 1'b1; end
                EXE_XOR_OP: begin w_logicRes = reg1_i ^ reg2_i;    w_logicValid = 1'b1; end
                EXE_NOR_OP: begin w_logicRes = ~(reg1_i | reg2_i); w_logicValid = 1'b1; end
                default: begin
                end
            endcase
        end
    end

    assign wd_o       = rst ? 5'd0 : wd_i;
    assign wreg_o     = rst ? 1'b0 : (w_logicValid & wreg_i);
    assign wdata_o    = rst ? '0 : w_logicRes;
    assign hi_o       = rst ? '0 : w_hi;
    assign lo_o       = rst ? '0 : w_lo;
    assign whilo_o    = rst ? 1'b0 : w_whilo;
    assign stallreq_o = rst ? 1'b0 : w_stall;

    // NOP and RES_NOP name the "no result" encodings; they fall to the defaults above.
    logic w_unusedNames;
    assign w_unusedNames = (EXE_NOP_OP == 8'd0) && (EXE_RES_NOP == 3'd0);

endmodule

// File: tb/tb_ex_div_stage.sv
// Directed bench for ex_div_stage: table of logic-op vectors plus hand-written
// divide, divide-by-zero, flush and reset sequences.
module tb_ex_div_stage;

    localparam logic [7:0] OP_NOP   = 8'b0000_0000;
    localparam logic [7:0] OP_AND   = 8'b0010_0100;
    localparam logic [7:0] OP_OR    = 8'b0010_0101;
    localparam logic [7:0] OP_XOR   = 8'b0010_0110;
    localparam logic [7:0] OP_NOR   = 8'b0010_0111;
    localparam logic [7:0] OP_DIV   = 8'b0001_1010;
    localparam logic [7:0] OP_DIVU  = 8'b0001_1011;
    localparam logic [2:0] RES_NOP  = 3'b000;
    localparam logic [2:0] RES_LOGIC = 3'b001;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        annul;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        stallreq_o;

    int errors = 0;
    int checks = 0;

    ex_div_stage #(.DATA_W(32), .DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop), .alusel_i(alusel),
        .reg1_i(reg1), .reg2_i(reg2), .wd_i(wd), .wreg_i(wreg), .annul_i(annul),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
        .whilo_o(whilo_o), .stallreq_o(stallreq_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    typedef struct {
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [31:0] reg1;
        logic [31:0] reg2;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] expData;
        logic        expWreg;
    } vec_t;

    vec_t vecs[8];

    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] dst, input logic we, input logic fl);
        aluop  = op;
        alusel = sel;
        reg1   = a;
        reg2   = b;
        wd     = dst;
        wreg   = we;
        annul  = fl;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idleCycle();
        @(posedge clk);
        #1 applyStimulus(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
    endtask

    // Issue a divide and follow it cycle by cycle until the HI/LO write.
    task automatic runDiv(input string name, input logic [7:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expLo, input logic [31:0] expHi,
                          input int expStall);
        int  stallCnt;
        bit  done;
        bit  bad;
        stallCnt = 0;
        done     = 1'b0;
        bad      = 1'b0;
        @(posedge clk);
        #1 applyStimulus(op, RES_NOP, a, b, 5'd9, 1'b1, 1'b0);
        for (int c = 0; c < 100 && !done; c++) begin
            @(negedge clk);
            if (wreg_o !== 1'b0 || wdata_o !== 32'd0) bad = 1'b1;
            if (whilo_o === 1'b1) begin
                done = 1'b1;
                checkOutput({name, " lo"}, lo_o, expLo);
                checkOutput({name, " hi"}, hi_o, expHi);
                checkOutput({name, " stallAtDone"}, 32'(stallreq_o), 32'd0);
            end else begin
                if (stallreq_o === 1'b1) stallCnt++;
                if (hi_o !== 32'd0 || lo_o !== 32'd0) bad = 1'b1;
            end
        end
        checkOutput({name, " reachedDone"}, 32'(done), 32'd1);
        checkOutput({name, " stallCycles"}, stallCnt, expStall);
        checkOutput({name, " noGprWrite"}, 32'(bad), 32'd0);
        idleCycle();
        @(negedge clk);
        checkOutput({name, " whiloOneCycle"}, 32'(whilo_o), 32'd0);
        checkOutput({name, " stallAfter"}, 32'(stallreq_o), 32'd0);
    endtask

    initial begin
        bit seenWhilo;
        bit seenStall;

        vecs[0] = '{OP_AND, RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd5,  1'b1, 32'h00F0_1234, 1'b1};
        vecs[1] = '{OP_NOR, RES_LOGIC, 32'h0000_0000, 32'hFFFF_0000, 5'd3,  1'b1, 32'h0000_FFFF, 1'b1};
        vecs[2] = '{OP_OR,  RES_LOGIC, 32'h1234_0000, 32'h0000_5678, 5'd31, 1'b1, 32'h1234_5678, 1'b1};
        vecs[3] = '{OP_XOR, RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd7,  1'b0, 32'hF0F0_0F0F, 1'b0};
        vecs[4] = '{OP_NOP, RES_NOP,   32'hAAAA_AAAA, 32'h5555_5555, 5'd4,  1'b1, 32'h0000_0000, 1'b0};
        vecs[5] = '{8'hFF,  RES_LOGIC, 32'hAAAA_AAAA, 32'h5555_5555, 5'd6,  1'b1, 32'h0000_0000, 1'b0};
        vecs[6] = '{OP_AND, RES_NOP,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8,  1'b1, 32'h0000_0000, 1'b0};
        vecs[7] = '{OP_AND, RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1,  1'b1, 32'hFFFF_FFFF, 1'b1};

        rst = 1'b1;
        applyStimulus(OP_AND, RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset wdata", wdata_o, 32'd0);
        checkOutput("reset wreg", 32'(wreg_o), 32'd0);
        checkOutput("reset wd", 32'(wd_o), 32'd0);
        checkOutput("reset stall", 32'(stallreq_o), 32'd0);
        checkOutput("reset whilo", 32'(whilo_o), 32'd0);
        checkOutput("reset hilo", hi_o | lo_o, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1 applyStimulus(vecs[i].aluop, vecs[i].alusel, vecs[i].reg1, vecs[i].reg2,
                             vecs[i].wd, vecs[i].wreg, 1'b0);
            @(negedge clk);
            checkOutput($sformatf("vec%0d wdata", i), wdata_o, vecs[i].expData);
            checkOutput($sformatf("vec%0d wreg", i), 32'(wreg_o), 32'(vecs[i].expWreg));
            checkOutput($sformatf("vec%0d wd", i), 32'(wd_o), 32'(vecs[i].wd));
            checkOutput($sformatf("vec%0d stall", i), 32'(stallreq_o), 32'd0);
            checkOutput($sformatf("vec%0d whilo", i), 32'(whilo_o), 32'd0);
        end
        idleCycle();

        runDiv("divu100by7", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);
        runDiv("divNeg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33);
        runDiv("div7byNeg2", OP_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 33);
        runDiv("divOverflow", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 33);
        runDiv("divuMaxBy1", OP_DIVU, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 33);
        runDiv("divByZero", OP_DIV, 32'd1234, 32'd0, 32'd0, 32'd0, 1);

        // Flush at BUSY iteration 10: the issue cycle plus ten BUSY cycles in.
        @(posedge clk);
        #1 applyStimulus(OP_DIVU, RES_NOP, 32'd100, 32'd7, 5'd9, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1 annul = 1'b1;
        @(negedge clk);
        checkOutput("annul stallDrops", 32'(stallreq_o), 32'd0);
        checkOutput("annul whilo", 32'(whilo_o), 32'd0);
        idleCycle();
        seenWhilo = 1'b0;
        seenStall = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (whilo_o === 1'b1) seenWhilo = 1'b1;
            if (stallreq_o === 1'b1) seenStall = 1'b1;
        end
        checkOutput("annul noLateWhilo", 32'(seenWhilo), 32'd0);
        checkOutput("annul noLateStall", 32'(seenStall), 32'd0);
        runDiv("divuAfterAnnul", OP_DIVU, 32'd9, 32'd3, 32'd3, 32'd0, 33);

        // Synchronous reset in the middle of a divide.
        @(posedge clk);
        #1 applyStimulus(OP_DIV, RES_NOP, 32'd500, 32'd3, 5'd9, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("midReset stall", 32'(stallreq_o), 32'd0);
        checkOutput("midReset wd", 32'(wd_o), 32'd0);
        checkOutput("midReset hilo", hi_o | lo_o, 32'd0);
        checkOutput("midReset whilo", 32'(whilo_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(OP_NOP, RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("afterReset stall", 32'(stallreq_o), 32'd0);
        runDiv("divuAfterReset", OP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
